// File: rtl/clock_pkg.sv
// Shared types, field limits and BCD helpers for the time-of-day core.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HR24_MAX = 23;
  localparam int HR12_MIN = 1;
  localparam int HR12_MAX = 12;

  function automatic int bcd2_bin(input bcd_t hi, input bcd_t lo);
    return int'(hi) * 10 + int'(lo);
  endfunction

  // Both digits must be legal BCD before the two-digit value is compared.
  function automatic logic bcd2_valid(input bcd_t hi, input bcd_t lo, input int max);
    return (hi <= 4'd9) && (lo <= 4'd9) && (bcd2_bin(hi, lo) <= max);
  endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD counter 00..MAX with parallel load; wrap flags the MAX->00 step.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic load_en,
  input  bcd_t load_hi,
  input  bcd_t load_lo,
  output bcd_t hi,
  output bcd_t lo,
  output logic wrap
);

  logic at_max;

  assign at_max = (bcd2_bin(hi, lo) == MAX);
  assign wrap   = inc && at_max;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (load_en) begin
      hi <= load_hi;
      lo <= load_lo;
    end else if (inc) begin
      if (at_max) begin
        hi <= '0;
        lo <= '0;
      end else if (lo == 4'd9) begin
        hi <= hi + 4'd1;
        lo <= '0;
      end else begin
        lo <= lo + 4'd1;
      end
    end
  end

endmodule

// File: rtl/time_set_counter.sv
// HH:MM:SS BCD time-of-day core with 1 s prescaler, validated load and per-field
// increment buttons; 24h or 12h (with pm flag) selected at elaboration.
module time_set_counter
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 50_000_000,
  parameter bit MODE_12H      = 1'b0,
  parameter int RESET_HH      = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic load,
  input  bcd_t in_hh,
  input  bcd_t in_hl,
  input  bcd_t in_mh,
  input  bcd_t in_ml,
  input  bcd_t in_sh,
  input  bcd_t in_sl,
  input  logic in_pm,
  input  logic inc_h,
  input  logic inc_m,
  input  logic inc_s,
  output bcd_t hh,
  output bcd_t hl,
  output bcd_t mh,
  output bcd_t ml,
  output bcd_t sh,
  output bcd_t sl,
  output logic pm,
  output logic sec_pulse,
  output logic day_wrap,
  output logic load_err
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_SEC - 1);

  // Reset hour folded into the active mode's range (0 -> 12 am in 12h mode).
  localparam int   RST_H24 = RESET_HH % 24;
  localparam int   RST_H12 = (RST_H24 % 12 == 0) ? 12 : (RST_H24 % 12);
  localparam int   RST_HR  = MODE_12H ? RST_H12 : RST_H24;
  localparam bit   RST_PM  = MODE_12H && (RST_H24 >= 12);
  localparam bcd_t RST_HH  = bcd_t'(RST_HR / 10);
  localparam bcd_t RST_HL  = bcd_t'(RST_HR % 10);

  logic          load_prev, inc_h_prev, inc_m_prev, inc_s_prev;
  logic          load_edge, inc_h_edge, inc_m_edge, inc_s_edge, any_inc;
  logic [PW-1:0] presc;
  logic          tick, tick_eff, load_ok, load_en;
  logic          sec_inc, min_inc, hr_step, sec_wrap, min_wrap;
  bcd_t          nxt_hh, nxt_hl;
  logic          nxt_pm, midnight;
  int            hr_bin;

  assign load_edge  = load  & ~load_prev;
  assign inc_h_edge = inc_h & ~inc_h_prev;
  assign inc_m_edge = inc_m & ~inc_m_prev;
  assign inc_s_edge = inc_s & ~inc_s_prev;
  assign any_inc    = inc_h_edge | inc_m_edge | inc_s_edge;

  // Priority load > buttons > tick; a pre-empted tick is simply lost.
  assign tick     = run && (presc == PS_LAST);
  assign tick_eff = tick && !load_edge && !any_inc;
  assign load_en  = load_edge && load_ok;
  assign sec_inc  = !load_edge && (inc_s_edge || tick_eff);
  assign min_inc  = !load_edge && (inc_m_edge || (tick_eff && sec_wrap));
  assign hr_step  = !load_edge && (inc_h_edge || (tick_eff && sec_wrap && min_wrap));
  assign hr_bin   = bcd2_bin(hh, hl);

  always_comb begin
    load_ok = bcd2_valid(in_sh, in_sl, SEC_MAX) && bcd2_valid(in_mh, in_ml, MIN_MAX);
    if (MODE_12H)
      load_ok = load_ok && bcd2_valid(in_hh, in_hl, HR12_MAX)
                && (bcd2_bin(in_hh, in_hl) >= HR12_MIN);
    else
      load_ok = load_ok && bcd2_valid(in_hh, in_hl, HR24_MAX);
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    nxt_hh   = hh;
    nxt_hl   = hl;
    nxt_pm   = pm;
    midnight = 1'b0;
    if (MODE_12H && hr_bin == HR12_MAX) begin
      nxt_hh = 4'd0;
      nxt_hl = 4'd1;
    end else if (MODE_12H && hr_bin == HR12_MAX - 1) begin
      nxt_hh   = 4'd1;
      nxt_hl   = 4'd2;
      nxt_pm   = ~pm;
      midnight = pm;
    end else if (!MODE_12H && hr_bin == HR24_MAX) begin
      nxt_hh   = 4'd0;
      nxt_hl   = 4'd0;
      midnight = 1'b1;
    end else if (hl == 4'd9) begin
      nxt_hh = hh + 4'd1;
      nxt_hl = 4'd0;
    end else begin
      nxt_hl = hl + 4'd1;
    end
  end

  bcd_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst), .inc(sec_inc), .load_en(load_en),
    .load_hi(in_sh), .load_lo(in_sl), .hi(sh), .lo(sl), .wrap(sec_wrap)
  );

  bcd_mod_counter #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .rst(rst), .inc(min_inc), .load_en(load_en),
    .load_hi(in_mh), .load_lo(in_ml), .hi(mh), .lo(ml), .wrap(min_wrap)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_prev  <= 1'b0;
      inc_h_prev <= 1'b0;
      inc_m_prev <= 1'b0;
      inc_s_prev <= 1'b0;
      presc      <= '0;
      hh         <= RST_HH;
      hl         <= RST_HL;
      pm         <= RST_PM;
      sec_pulse  <= 1'b0;
      day_wrap   <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      load_prev  <= load;
      inc_h_prev <= inc_h;
      inc_m_prev <= inc_m;
      inc_s_prev <= inc_s;

      if (load_en)
        presc <= '0;
      else if (run)
        presc <= (presc == PS_LAST) ? '0 : presc + PW'(1);

      if (load_en) begin
        hh <= in_hh;
        hl <= in_hl;
        pm <= MODE_12H ? in_pm : 1'b0;
      end else if (hr_step) begin
        hh <= nxt_hh;
        hl <= nxt_hl;
        pm <= nxt_pm;
      end

      sec_pulse <= tick_eff;
      day_wrap  <= tick_eff && sec_wrap && min_wrap && midnight;
      load_err  <= load_edge && !load_ok;
    end
  end

endmodule

// File: tb/tb_time_set_counter.sv
// Directed bench: 24h and 12h cores ticking every cycle plus a 24h core with a
// 4-cycle prescaler, all sharing load/button inputs.
module tb_time_set_counter;

  typedef enum logic {OP_LOAD, OP_INC} op_e;

  typedef struct {
    op_e         op;
    logic [23:0] din;
    logic        pm;
    logic [2:0]  hms;
    logic [23:0] e24;
    logic        err24;
    logic [23:0] e12;
    logic        pm12;
    logic        err12;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        run24, run12, runp;
  logic        load, in_pm, inc_h, inc_m, inc_s;
  logic [23:0] din;

  wire [23:0] t24, t12, tp;
  wire        pm24, pm12, pmp;
  wire        sp24, sp12, spp;
  wire        dw24, dw12, dwp;
  wire        le24, le12, lep;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t vecs[15];

  always #5 clk = ~clk;

  time_set_counter #(.TICKS_PER_SEC(1), .MODE_12H(1'b0), .RESET_HH(0)) u24 (
    .clk(clk), .rst(rst), .run(run24), .load(load),
    .in_hh(din[23:20]), .in_hl(din[19:16]), .in_mh(din[15:12]),
    .in_ml(din[11:8]), .in_sh(din[7:4]), .in_sl(din[3:0]), .in_pm(in_pm),
    .inc_h(inc_h), .inc_m(inc_m), .inc_s(inc_s),
    .hh(t24[23:20]), .hl(t24[19:16]), .mh(t24[15:12]),
    .ml(t24[11:8]), .sh(t24[7:4]), .sl(t24[3:0]), .pm(pm24),
    .sec_pulse(sp24), .day_wrap(dw24), .load_err(le24)
  );

  time_set_counter #(.TICKS_PER_SEC(1), .MODE_12H(1'b1), .RESET_HH(0)) u12 (
    .clk(clk), .rst(rst), .run(run12), .load(load),
    .in_hh(din[23:20]), .in_hl(din[19:16]), .in_mh(din[15:12]),
    .in_ml(din[11:8]), .in_sh(din[7:4]), .in_sl(din[3:0]), .in_pm(in_pm),
    .inc_h(inc_h), .inc_m(inc_m), .inc_s(inc_s),
    .hh(t12[23:20]), .hl(t12[19:16]), .mh(t12[15:12]),
    .ml(t12[11:8]), .sh(t12[7:4]), .sl(t12[3:0]), .pm(pm12),
    .sec_pulse(sp12), .day_wrap(dw12), .load_err(le12)
  );

  time_set_counter #(.TICKS_PER_SEC(4), .MODE_12H(1'b0), .RESET_HH(0)) up (
    .clk(clk), .rst(rst), .run(runp), .load(load),
    .in_hh(din[23:20]), .in_hl(din[19:16]), .in_mh(din[15:12]),
    .in_ml(din[11:8]), .in_sh(din[7:4]), .in_sl(din[3:0]), .in_pm(in_pm),
    .inc_h(inc_h), .inc_m(inc_m), .inc_s(inc_s),
    .hh(tp[23:20]), .hl(tp[19:16]), .mh(tp[15:12]),
    .ml(tp[11:8]), .sh(tp[7:4]), .sl(tp[3:0]), .pm(pmp),
    .sec_pulse(spp), .day_wrap(dwp), .load_err(lep)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [23:0] t, input logic p);
    din   = t;
    in_pm = p;
    load  = 1'b1;
    step();
    load  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //                op       din        pm    hms     e24     err24  e12     pm12  err12
    vecs[0]  = '{OP_LOAD, 24'h123456, 1'b0, 3'b000, 24'h123456, 1'b0, 24'h123456, 1'b0, 1'b0};
    vecs[1]  = '{OP_LOAD, 24'h240000, 1'b0, 3'b000, 24'h123456, 1'b1, 24'h123456, 1'b0, 1'b1};
    vecs[2]  = '{OP_LOAD, 24'h00000A, 1'b0, 3'b000, 24'h123456, 1'b1, 24'h123456, 1'b0, 1'b1};
    vecs[3]  = '{OP_LOAD, 24'h105959, 1'b1, 3'b000, 24'h105959, 1'b0, 24'h105959, 1'b1, 1'b0};
    vecs[4]  = '{OP_INC,  24'h000000, 1'b0, 3'b001, 24'h105900, 1'b0, 24'h105900, 1'b1, 1'b0};
    vecs[5]  = '{OP_INC,  24'h000000, 1'b0, 3'b010, 24'h100000, 1'b0, 24'h100000, 1'b1, 1'b0};
    vecs[6]  = '{OP_LOAD, 24'h230730, 1'b0, 3'b000, 24'h230730, 1'b0, 24'h100000, 1'b1, 1'b1};
    vecs[7]  = '{OP_INC,  24'h000000, 1'b0, 3'b100, 24'h000730, 1'b0, 24'h110000, 1'b1, 1'b0};
    vecs[8]  = '{OP_INC,  24'h000000, 1'b0, 3'b100, 24'h010730, 1'b0, 24'h120000, 1'b0, 1'b0};
    vecs[9]  = '{OP_INC,  24'h000000, 1'b0, 3'b100, 24'h020730, 1'b0, 24'h010000, 1'b0, 1'b0};
    vecs[10] = '{OP_INC,  24'h000000, 1'b0, 3'b111, 24'h030831, 1'b0, 24'h020101, 1'b0, 1'b0};
    vecs[11] = '{OP_LOAD, 24'h000000, 1'b0, 3'b000, 24'h000000, 1'b0, 24'h020101, 1'b0, 1'b1};
    vecs[12] = '{OP_LOAD, 24'h096000, 1'b0, 3'b000, 24'h000000, 1'b1, 24'h020101, 1'b0, 1'b1};
    vecs[13] = '{OP_LOAD, 24'h195959, 1'b1, 3'b000, 24'h195959, 1'b0, 24'h020101, 1'b0, 1'b1};
    vecs[14] = '{OP_INC,  24'h000000, 1'b0, 3'b100, 24'h205959, 1'b0, 24'h030101, 1'b0, 1'b0};

    rst = 1'b1;
    {run24, run12, runp, load, in_pm, inc_h, inc_m, inc_s} = '0;
    din = '0;
    step();
    step();
    rst = 1'b0;

    check("reset t24", t24, 24'h000000);
    check("reset pm24", pm24, 1'b0);
    check("reset t12", t12, 24'h120000);
    check("reset pm12", pm12, 1'b0);
    check("reset tp", tp, 24'h000000);
    check("reset strobes24", {sp24, dw24, le24}, 3'b000);
    check("reset strobes12", {sp12, dw12, le12}, 3'b000);

    // Reset asserted between edges while the 24h core is counting.
    run24 = 1'b1;
    repeat (5) step();
    check("run 5s t24", t24, 24'h000005);
    check("run sec_pulse24", sp24, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst t24", t24, 24'h000000);
    check("async rst strobes24", {sp24, dw24, le24, pm24}, 4'b0000);
    check("async rst t12", t12, 24'h120000);
    run24 = 1'b0;
    step();
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      if (vecs[i].op == OP_LOAD) begin
        din   = vecs[i].din;
        in_pm = vecs[i].pm;
        load  = 1'b1;
      end else begin
        {inc_h, inc_m, inc_s} = vecs[i].hms;
      end
      step();
      {load, inc_h, inc_m, inc_s} = '0;
      check($sformatf("vec%0d t24", i), t24, vecs[i].e24);
      check($sformatf("vec%0d pm24", i), pm24, 1'b0);
      check($sformatf("vec%0d load_err24", i), le24, vecs[i].err24);
      check($sformatf("vec%0d t12", i), t12, vecs[i].e12);
      check($sformatf("vec%0d pm12", i), pm12, vecs[i].pm12);
      check($sformatf("vec%0d load_err12", i), le12, vecs[i].err12);
      step();
      check($sformatf("vec%0d err strobe end", i), {le24, le12}, 2'b00);
    end

    // 24h midnight roll with a tick every cycle.
    do_load(24'h235958, 1'b0);
    check("pre-wrap t24", t24, 24'h235958);
    run24 = 1'b1;
    step();
    check("t24 235959", t24, 24'h235959);
    check("sp/dw24 @59", {sp24, dw24}, 2'b10);
    step();
    check("t24 wrap", t24, 24'h000000);
    check("sp/dw24 @wrap", {sp24, dw24}, 2'b11);
    step();
    check("t24 000001", t24, 24'h000001);
    check("sp/dw24 after", {sp24, dw24}, 2'b10);
    run24 = 1'b0;
    step();
    check("sp24 stops", sp24, 1'b0);

    // 12h transitions.
    do_load(24'h115959, 1'b0);
    run12 = 1'b1;
    step();
    run12 = 1'b0;
    check("12h noon t12", t12, 24'h120000);
    check("12h noon pm/dw/sp", {pm12, dw12, sp12}, 3'b101);
    do_load(24'h125959, 1'b0);
    run12 = 1'b1;
    step();
    run12 = 1'b0;
    check("12h 12->01 t12", t12, 24'h010000);
    check("12h 12->01 pm", pm12, 1'b0);
    do_load(24'h115959, 1'b1);
    run12 = 1'b1;
    step();
    run12 = 1'b0;
    check("12h midnight t12", t12, 24'h120000);
    check("12h midnight pm/dw", {pm12, dw12}, 2'b01);
    step();
    check("12h dw strobe end", dw12, 1'b0);

    // Prescaled core: load beats a coincident tick and inc_m edge.
    do_load(24'h000000, 1'b0);
    runp = 1'b1;
    repeat (3) step();
    check("tp before tick", tp, 24'h000000);
    din   = 24'h123456;
    load  = 1'b1;
    inc_m = 1'b1;
    step();
    {load, inc_m} = '0;
    check("load wins tp", tp, 24'h123456);
    check("load wins sp", spp, 1'b0);
    repeat (3) step();
    check("tp hold 3", tp, 24'h123456);
    step();
    check("tp tick 4", tp, 24'h123457);
    check("tp tick sp", spp, 1'b1);

    // Mid-count load must restart the prescaler.
    step();
    do_load(24'h000000, 1'b0);
    repeat (3) step();
    check("restart hold", tp, 24'h000000);
    step();
    check("restart tick", tp, 24'h000001);

    // Holding a button produces exactly one bump.
    runp  = 1'b0;
    inc_m = 1'b1;
    step();
    check("inc_m held first", tp, 24'h000101);
    repeat (9) step();
    check("inc_m held 10", tp, 24'h000101);
    inc_m = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
